// File: rtl/mem_access_ctrl.sv
// Multi-cycle sequencer from the control unit's Mem_OE/Mem_WE strobes to an asynchronous SRAM.
// Define MEM_IO_MAP_EN so that accesses to IO_ADDR go to Switches/HEX_Data and not to SRAM.
module mem_access_ctrl #(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic [15:0] Data_to_CPU,
    output logic        Mem_Rdy,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    inout  wire  [15:0] SRAM_DQ,
    input  logic [15:0] Switches,
    output logic [15:0] HEX_Data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        io_q, io_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hex_q, hex_d;
    logic        rdy_q, rdy_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic        io_hit;
    logic        is_io;
    logic        rd_active;
    logic        wr_active;

    assign io_hit = (MAR == IO_ADDR);

`ifdef MEM_IO_MAP_EN
    assign is_io    = io_hit;
    assign HEX_Data = hex_q;
`else
    logic unused_io;
    assign is_io     = 1'b0;
    assign HEX_Data  = '0;
    assign unused_io = io_hit | (|hex_q);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        io_d    = io_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        rdy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Write wins when both requests are raised together
                if (Mem_WE) begin
                    state_d = WR_WAIT;
                    addr_d  = {4'b0, MAR};
                    wdata_d = MDR;
                    io_d    = is_io;
                    cnt_d   = is_io ? 4'd0 : WS_LOAD;
                end else if (Mem_OE) begin
                    state_d = RD_WAIT;
                    addr_d  = {4'b0, MAR};
                    io_d    = is_io;
                    cnt_d   = is_io ? 4'd0 : WS_LOAD;
                end
            end
            RD_WAIT: begin
                if (!Mem_OE) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    rdata_d = io_q ? Switches : SRAM_DQ;
                    rdy_d   = 1'b1;
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_WAIT: begin
                if (!Mem_WE) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    if (io_q) begin
                        hex_d = wdata_q;
                    end
                    rdy_d   = 1'b1;
                    state_d = WR_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_DONE: begin
                if (!Mem_OE) begin
                    state_d = IDLE;
                end
            end
            WR_DONE: begin
                if (!Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so that they are registered together with it
        rd_active = (state_d == RD_WAIT) && !io_d;
        wr_active = (state_d == WR_WAIT) && !io_d;
        ce_n_d    = !(rd_active || wr_active);
        oe_n_d    = !rd_active;
        we_n_d    = !wr_active;
        dq_oe_d   = wr_active;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            io_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
            rdy_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            io_q    <= io_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            rdy_q   <= rdy_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign Data_to_CPU = rdata_q;
    assign Mem_Rdy     = rdy_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_UB_N   = ce_n_q;
    assign SRAM_LB_N   = ce_n_q;
    assign SRAM_DQ     = dq_oe_q ? wdata_q : 16'hzzzz;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle memory access sequencer between the control unit's `Mem_OE`/`Mem_WE` strobes and the external asynchronous SRAM. It sequences chip-enable, output-enable and write-enable with a programmable wait-state count, and returns read data to the datapath MDR input. It signals completion with a one-cycle `Mem_Rdy` pulse. Optionally it decodes the memory-mapped I/O word (switches in, hex display out) so those accesses never reach SRAM.

## Interface
- `WAIT_STATES`, default 2: SRAM access cycles per read/write; legal range 1..15.
- `IO_ADDR`, default 16'hFFFF: memory-mapped I/O address.
- `Clk` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Mem_OE` in 1: read request from control unit, active-high level.
- `Mem_WE` in 1: write request from control unit, active-high level.
- `MAR` in 16: access address.
- `MDR` in 16: write data.
- `Data_to_CPU` out 16: registered read data to MDR mux.
- `Mem_Rdy` out 1: one-cycle completion pulse.
- `SRAM_ADDR` out 20: SRAM address, {4'b0, MAR}.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: active-low SRAM strobes.
- `SRAM_DQ` inout 16: SRAM data bus.
- `Switches` in 16: board switches; used only with I/O map compiled in.
- `HEX_Data` out 16: hex display register; used only with I/O map compiled in.

## Operation
- States: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE. 4-bit wait counter `cnt`.
- IDLE:
  - `Mem_WE` high: latch MAR/MDR, `cnt`=WAIT_STATES-1, go to WR_WAIT. Write has priority when `Mem_OE` and `Mem_WE` are both high.
  - Else `Mem_OE` high: latch MAR, `cnt`=WAIT_STATES-1, go to RD_WAIT.
- RD_WAIT:
  - Assert CE_N=0, OE_N=0, UB_N=LB_N=0.
  - When `cnt`==0: capture SRAM_DQ into `Data_to_CPU`, pulse `Mem_Rdy`, go to RD_DONE.
  - Otherwise decrement `cnt`.
- WR_WAIT:
  - Assert CE_N=0, WE_N=0, UB_N=LB_N=0; drive SRAM_DQ=latched MDR.
  - When `cnt`==0: pulse `Mem_Rdy`, go to WR_DONE.
  - Otherwise decrement `cnt`.
- RD_DONE / WR_DONE: all strobes inactive. Hold the state until the respective request drops, then return to IDLE. A held strobe never causes a second access.
- Abort: request drops while in RD_WAIT or WR_WAIT:
  - Go to IDLE next edge; strobes deassert that edge.
  - No `Mem_Rdy`; `Data_to_CPU` unchanged.
- SRAM_DQ is high-Z in every state except WR_WAIT.
- `Data_to_CPU` holds its last captured value between reads.
- Address/data are latched on request acceptance. MAR changes mid-access are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` = 1.
  - `SRAM_ADDR`=0, `Data_to_CPU`=0, `Mem_Rdy`=0, `HEX_Data`=0.
  - SRAM_DQ high-Z.
- Reset asserted mid-access forces all of the above immediately, without waiting for a clock edge.
- Request seen at edge n (IDLE): strobes active from edge n+1 through n+WAIT_STATES.
- `Mem_Rdy` is high during the cycle after edge n+WAIT_STATES. Read data is valid in `Data_to_CPU` in that same cycle.
- With WAIT_STATES=2: `Mem_Rdy` appears two cycles after request acceptance. The control unit's 2-cycle OE window followed by LD_MDR aligns with this.
- Back-to-back requests: minimum one IDLE cycle between accesses, because a request must first be seen low in a DONE state.
- All outputs are registered; no combinational path from `Mem_OE`/`Mem_WE` to the SRAM pins.

## Configuration
- `MEM_IO_MAP_EN` defined: accesses with MAR==IO_ADDR bypass SRAM.
  - Read: `Data_to_CPU`=Switches, `Mem_Rdy` one cycle after acceptance (no wait states); SRAM strobes stay inactive.
  - Write: `HEX_Data`<=MDR and `Mem_Rdy` one cycle after acceptance.
- `MEM_IO_MAP_EN` undefined: IO_ADDR is ordinary SRAM; `HEX_Data` is tied to 0 and `Switches` is unused.

## Test plan
- Reset mid-RD_WAIT, then release → all strobes 1, DQ high-Z, `Data_to_CPU`=0, state IDLE; next `Mem_OE` starts a fresh read.
- WAIT_STATES=2, MAR=16'h0042, SRAM model returns 16'hBEEF, `Mem_OE` held 3 cycles → OE_N low 2 cycles, SRAM_ADDR=20'h00042, `Mem_Rdy` one pulse, `Data_to_CPU`=16'hBEEF, no second access.
- Write MAR=16'h0100, MDR=16'h1234 → WE_N low 2 cycles, DQ=16'h1234 only during WE_N low, one `Mem_Rdy` pulse; readback returns 16'h1234.
- `Mem_OE` and `Mem_WE` both high in IDLE → write performed, OE_N stays 1.
- `Mem_OE` dropped after 1 cycle of RD_WAIT → strobes inactive next edge, no `Mem_Rdy`, `Data_to_CPU` unchanged.
- With `MEM_IO_MAP_EN`, Switches=16'h00A5:
  - Read at 16'hFFFF → `Data_to_CPU`=16'h00A5 after 1 cycle, CE_N stays 1.
  - Write MDR=16'h0007 to 16'hFFFF → `HEX_Data`=16'h0007.
